// File: rtl/alu_exec_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 2A03 ALU execution controller:
//   - ALU operation codes driven on alu_op
//   - request (decoded instruction) codes accepted on req_op
//   - controller FSM state encoding
//   - bit positions inside the {N,V,Z,C} flag vector
//   - small classification helpers for request codes
// -----------------------------------------------------------------------------
package alu_pkg;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_EOR  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_AND  = 4'h4;
    localparam logic [3:0] ALU_INC  = 4'h5;
    localparam logic [3:0] ALU_DEC  = 4'h6;
    localparam logic [3:0] ALU_ROR  = 4'h7;
    localparam logic [3:0] ALU_ROL  = 4'h8;
    localparam logic [3:0] ALU_ASL  = 4'h9;
    localparam logic [3:0] ALU_LSR  = 4'hA;
    localparam logic [3:0] ALU_PASS = 4'hF;

    // Request codes
    localparam logic [4:0] OP_ADC   = 5'd0;
    localparam logic [4:0] OP_SBC   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_ORA   = 5'd3;
    localparam logic [4:0] OP_EOR   = 5'd4;
    localparam logic [4:0] OP_CMP   = 5'd5;
    localparam logic [4:0] OP_BIT   = 5'd6;
    localparam logic [4:0] OP_LDA   = 5'd7;
    localparam logic [4:0] OP_ASL_A = 5'd8;
    localparam logic [4:0] OP_LSR_A = 5'd9;
    localparam logic [4:0] OP_ROL_A = 5'd10;
    localparam logic [4:0] OP_ROR_A = 5'd11;
    localparam logic [4:0] OP_INC_M = 5'd12;
    localparam logic [4:0] OP_DEC_M = 5'd13;
    localparam logic [4:0] OP_ASL_M = 5'd14;
    localparam logic [4:0] OP_LSR_M = 5'd15;
    localparam logic [4:0] OP_ROL_M = 5'd16;
    localparam logic [4:0] OP_ROR_M = 5'd17;
    localparam logic [4:0] OP_CLC   = 5'd18;
    localparam logic [4:0] OP_SEC   = 5'd19;
    localparam logic [4:0] OP_CLV   = 5'd20;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Flag bit positions in flags_nvzc
    localparam int FLAG_N = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    function automatic logic op_is_legal(input logic [4:0] op);
        return op <= OP_CLV;
    endfunction

    // Flag-only instructions complete in IDLE without using the ALU
    function automatic logic op_is_flag(input logic [4:0] op);
        return (op >= OP_CLC) && (op <= OP_CLV);
    endfunction

    // Read-modify-write memory instructions return their result via writeback
    function automatic logic op_is_rmw(input logic [4:0] op);
        return (op >= OP_INC_M) && (op <= OP_ROR_M);
    endfunction

    function automatic logic op_is_acc_shift(input logic [4:0] op);
        return (op >= OP_ASL_A) && (op <= OP_ROR_A);
    endfunction

    function automatic logic op_is_shift(input logic [4:0] op);
        return op_is_acc_shift(op) || ((op >= OP_ASL_M) && (op <= OP_ROR_M));
    endfunction

    function automatic logic op_writes_acc(input logic [4:0] op);
        return (op == OP_ADC) || (op == OP_SBC) || (op == OP_AND) ||
               (op == OP_ORA) || (op == OP_EOR) || (op == OP_LDA) ||
               op_is_acc_shift(op);
    endfunction

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        logic [3:0] code;
        case (op)
            OP_ADC:             code = ALU_ADD;
            OP_SBC, OP_CMP:     code = ALU_SUB;
            OP_AND, OP_BIT:     code = ALU_AND;
            OP_ORA:             code = ALU_OR;
            OP_EOR:             code = ALU_EOR;
            OP_ASL_A, OP_ASL_M: code = ALU_ASL;
            OP_LSR_A, OP_LSR_M: code = ALU_LSR;
            OP_ROL_A, OP_ROL_M: code = ALU_ROL;
            OP_ROR_A, OP_ROR_M: code = ALU_ROR;
            OP_INC_M:           code = ALU_INC;
            OP_DEC_M:           code = ALU_DEC;
            default:            code = ALU_PASS;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_exec_if
// Request and writeback handshakes of the ALU execution controller.
//   req_valid/req_ready/req_op/req_operand : instruction request
//   wb_valid/wb_ready/wb_data              : read-modify-write result return
// master : decoder / bus unit side
// slave  : controller side
// -----------------------------------------------------------------------------
interface alu_exec_if;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_op;
    logic [7:0] req_operand;
    logic       wb_valid;
    logic [7:0] wb_data;
    logic       wb_ready;

    modport master (
        output req_valid, req_op, req_operand, wb_ready,
        input  req_ready, wb_valid, wb_data
    );

    modport slave (
        input  req_valid, req_op, req_operand, wb_ready,
        output req_ready, wb_valid, wb_data
    );
endinterface

// File: rtl/alu_exec_ctrl_flag_update.sv
// -----------------------------------------------------------------------------
// alu_flag_update
// Combinational next-{N,V,Z,C} for an ALU-class instruction.
//   op         : latched request code
//   res        : ALU result byte (alu_f[7:0])
//   alu_carry  : ALU carry-out flag
//   alu_ovf    : ALU overflow flag
//   operand    : latched memory/immediate operand
//   acc        : current accumulator (needed by BIT)
//   flags_in   : current {N,V,Z,C}
//   flags_next : {N,V,Z,C} to capture at the end of EXEC
// -----------------------------------------------------------------------------
module alu_flag_update
    import alu_pkg::*;
(
    input  logic [4:0] op,
    input  logic [7:0] res,
    input  logic       alu_carry,
    input  logic       alu_ovf,
    input  logic [7:0] operand,
    input  logic [7:0] acc,
    input  logic [3:0] flags_in,
    output logic [3:0] flags_next
);

    always_comb begin
        flags_next = flags_in;
        if (op == OP_BIT) begin
            // BIT looks at the operand itself rather than the ALU result
            flags_next[FLAG_N] = operand[7];
            flags_next[FLAG_V] = operand[6];
            flags_next[FLAG_Z] = ((acc & operand) == 8'h00);
        end else begin
            // N/Z are always recomputed locally from the result byte
            flags_next[FLAG_N] = res[7];
            flags_next[FLAG_Z] = (res == 8'h00);
            if ((op == OP_ADC) || (op == OP_SBC)) begin
                flags_next[FLAG_C] = alu_carry;
                flags_next[FLAG_V] = alu_ovf;
            end else if ((op == OP_CMP) || op_is_shift(op)) begin
                flags_next[FLAG_C] = alu_carry;
            end
        end
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// alu_exec_ctrl
// Command-side execution controller for the 2A03 ALU. Accepts one decoded
// ALU-class instruction at a time, drives the external combinational ALU for
// one EXEC cycle, owns accumulator A and the N/V/Z/C flags, and returns
// read-modify-write results through a writeback handshake.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : request and writeback handshakes
//   alu_op/a/b      : ALU operation and data inputs
//   alu_carry_in    : ALU carry input
//   alu_overflow_in : ALU overflow input
//   alu_f           : ALU result, bit 8 is carry-out
//   alu_carry       : ALU carry flag
//   alu_overflow    : ALU overflow flag
//   acc             : accumulator A
//   flags_nvzc      : {N,V,Z,C}
//   busy            : controller not in IDLE
//   err             : one-cycle pulse after an illegal request code
// -----------------------------------------------------------------------------
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter bit ILLEGAL_ERR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus,
    output logic [3:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_carry_in,
    output logic       alu_overflow_in,
    input  logic [8:0] alu_f,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    output logic [7:0] acc,
    output logic [3:0] flags_nvzc,
    output logic       busy,
    output logic       err
);

    state_t     state_reg, state_next;
    logic [4:0] op_reg;
    logic [7:0] operand_reg;
    logic [7:0] acc_reg;
    logic [3:0] flags_reg;
    logic [3:0] flags_next;
    logic [7:0] wb_data_reg;
    logic       err_reg;
    logic       accept;

    // Carry is taken from alu_carry; the duplicate carry-out in alu_f is not needed
    logic unused_alu_f8;
    assign unused_alu_f8 = alu_f[8];

    assign accept = (state_reg == ST_IDLE) && bus.req_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                // Illegal and flag-only requests never leave IDLE
                if (accept && op_is_legal(bus.req_op) && !op_is_flag(bus.req_op)) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = op_is_rmw(op_reg) ? ST_WB : ST_IDLE;
            end
            ST_WB: begin
                if (bus.wb_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy            = (state_reg != ST_IDLE);
        alu_op          = ALU_PASS;
        alu_a           = 8'h00;
        alu_b           = 8'h00;
        alu_carry_in    = 1'b0;
        alu_overflow_in = 1'b0;
        if (state_reg == ST_EXEC) begin
            alu_op          = alu_code(op_reg);
            alu_a           = ((op_reg == OP_LDA) || op_is_rmw(op_reg)) ? operand_reg : acc_reg;
            alu_b           = op_is_acc_shift(op_reg) ? acc_reg : operand_reg;
            // CMP is a subtract with no incoming borrow
            alu_carry_in    = (op_reg == OP_CMP) ? 1'b1 : flags_reg[FLAG_C];
            alu_overflow_in = flags_reg[FLAG_V];
        end
    end

    assign bus.req_ready = (state_reg == ST_IDLE);
    assign bus.wb_valid  = (state_reg == ST_WB);
    assign bus.wb_data   = wb_data_reg;
    assign acc           = acc_reg;
    assign flags_nvzc    = flags_reg;
    assign err           = err_reg;

    alu_flag_update u_flag_update (
        .op         (op_reg),
        .res        (alu_f[7:0]),
        .alu_carry  (alu_carry),
        .alu_ovf    (alu_overflow),
        .operand    (operand_reg),
        .acc        (acc_reg),
        .flags_in   (flags_reg),
        .flags_next (flags_next)
    );

    // Architectural state and request latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg      <= OP_LDA;
            operand_reg <= 8'h00;
            acc_reg     <= 8'h00;
            flags_reg   <= 4'h0;
            wb_data_reg <= 8'h00;
            err_reg     <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (!op_is_legal(bus.req_op)) begin
                            err_reg <= ILLEGAL_ERR;
                        end else if (bus.req_op == OP_CLC) begin
                            flags_reg[FLAG_C] <= 1'b0;
                        end else if (bus.req_op == OP_SEC) begin
                            flags_reg[FLAG_C] <= 1'b1;
                        end else if (bus.req_op == OP_CLV) begin
                            flags_reg[FLAG_V] <= 1'b0;
                        end else begin
                            op_reg      <= bus.req_op;
                            operand_reg <= bus.req_operand;
                        end
                    end
                end
                ST_EXEC: begin
                    flags_reg <= flags_next;
                    if (op_writes_acc(op_reg)) begin
                        acc_reg <= alu_f[7:0];
                    end
                    if (op_is_rmw(op_reg)) begin
                        wb_data_reg <= alu_f[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Execution controller on the command side of the 2A03 ALU. It accepts one decoded ALU-class instruction at a time, sequences the ALU opcode, operands and carry/overflow inputs, and owns the accumulator A and the N/V/Z/C flags. Read-modify-write memory results are returned through a writeback handshake. It sits between the instruction decoder/bus unit and the combinational ALU.

Parameters:
ILLEGAL_ERR, 1, when 1, pulse err on an undefined req_op; when 0, silently drop it.

Ports:
clk  in  1  the single clock
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request strobe
req_ready  out  1  controller can accept a request
req_op  in  5  instruction code (see Behaviour)
req_operand  in  8  memory/immediate operand
alu_op  out  4  ALU operation code
alu_a  out  8  ALU a input
alu_b  out  8  ALU b input
alu_carry_in  out  1  ALU carryIn
alu_overflow_in  out  1  ALU overflowIn
alu_f  in  9  ALU result; bit 8 is carry-out
alu_carry  in  1  ALU carry flag
alu_overflow  in  1  ALU overflow flag
wb_valid  out  1  RMW result available
wb_data  out  8  RMW result
wb_ready  in  1  consumer accepts wb_data
acc  out  8  accumulator A
flags_nvzc  out  4  {N,V,Z,C}
busy  out  1  high when not in IDLE
err  out  1  one-cycle pulse for an illegal req_op

Behaviour:
- ALU op codes: 0 ADD, 1 SUB (borrow = ~carryIn; carry out = not-borrow), 2 EOR, 3 OR, 4 AND, 5 INC a, 6 DEC a, 7 ROR b, 8 ROL b, 9 ASL b, A LSR b, F pass a.
- req_op codes:
  - 0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 CMP, 6 BIT, 7 LDA.
  - 8–11 ASL/LSR/ROL/ROR on A.
  - 12–17 INC/DEC/ASL/LSR/ROL/ROR on memory.
  - 18 CLC, 19 SEC, 20 CLV.
  - 21–31 illegal.
- Reset (async, rst_n low):
  - State IDLE; acc=0, flags_nvzc=0.
  - wb_valid=0, wb_data=0, err=0, busy=0, req_ready=1.
  - ALU outputs are set to op F with all data inputs 0.
- FSM states: IDLE, EXEC, WB.
  - IDLE: req_ready=1. On req_valid, latch op and operand. A legal op goes to EXEC. An illegal op stays in IDLE, pulses err next cycle, and changes no state. CLC/SEC/CLV update their flag directly and stay in IDLE (1-cycle latency).
  - EXEC (one cycle): req_ready=0. The ALU is driven combinationally from the latched op. On the clock edge, capture results. RMW ops go to WB; all other ops go to IDLE. A/flags become visible 2 edges after acceptance.
  - WB: wb_valid=1 and wb_data is held stable. Leave on wb_ready=1 at an edge; wb_valid drops the same edge. Wait indefinitely otherwise.
- ALU drive in EXEC:
  - alu_a = A for ADC/SBC/AND/ORA/EOR/CMP/BIT and accumulator shifts.
  - alu_a = operand for INC/DEC/LDA and memory shifts.
  - alu_b is the operand, or A for accumulator shifts.
  - alu_carry_in = C, except CMP forces 1.
  - alu_overflow_in = V.
  - alu_op follows the natural mapping: CMP→1, BIT→4, LDA→F.
- Outside EXEC, the ALU is driven with op F and zero data.
- Flag rules:
  - N and Z are always derived here from alu_f[7:0]; the ALU's N/Z are not used.
  - C is taken from alu_carry for ADC/SBC/CMP and all shifts/rotates.
  - V is taken from alu_overflow for ADC/SBC only.
  - BIT: Z from A&operand, N=operand[7], V=operand[6], A unchanged.
  - CMP: A and V unchanged.
  - INC/DEC/AND/ORA/EOR/LDA leave C and V unchanged.
- A is written by ADC/SBC/AND/ORA/EOR/LDA and accumulator shifts. wb_data is written only by RMW ops.
- Boundaries:
  - Arithmetic wraps modulo 256 (0xFF INC → 0x00, Z=1; 0x00 DEC → 0xFF, N=1).
  - A request presented while busy is ignored (not accepted).
  - Reset in any state aborts immediately: a pending wb_valid is dropped and no A/flag update occurs.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode localparams (ADD..LSR, PASS=F);
  - req_op encoding constants;
  - FSM state encoding;
  - flag bit indices.
- One sub-module, alu_flag_update: combinational next-N/V/Z/C from op class, alu_f, alu_carry, alu_overflow and operand. The ALU itself is instantiated at the top level, not inside this block.

Test Plan:
- Reset, then LDA 0x50 and ADC 0x50 with C=0 → acc=0xA0, NVZC=1100; busy high exactly 1 cycle per op.
- SEC, LDA 0x00, SBC 0x01 → acc=0xFF, N=1, V=0, Z=0, C=0; SEC updates C=1 in 1 cycle.
- LDA 0x40, then CMP 0x40 → acc=0x40, Z=1, C=1, N=0, V unchanged; alu_carry_in observed =1 during EXEC.
- SEC, ROL_M 0x80; hold wb_ready=0 for 3 cycles → wb_valid=1, wb_data=0x01, C=1, req_ready=0 throughout. A req_valid during WB is not accepted. wb_ready=1 → IDLE next edge.
- LDA 0x0F, BIT 0xC0 → Z=1, N=1, V=1, acc=0x0F. INC_M 0xFF → wb_data=0x00, Z=1, C unchanged.
- req_op=25 → err pulse 1 cycle, flags/acc unchanged. Assert rst_n=0 mid-WB → wb_valid=0, acc=0, flags=0 immediately, without a clock edge.
